// File: rtl/raster_line_sched.sv
// raster_line_sched
// Per-line setup scheduler for the scanline rasterizer. Holds per-frame start
// values and per-line increments for 6 edge functions and 4 barycentric terms.
// The values are loaded at frame start (COMMIT) and stepped once per visible line
// (STEP) during hblank, one slot per cycle, through a single shared adder.
module raster_line_sched #(
  parameter int W_E      = 20,
  parameter int W_B      = 22,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [4:0]            cfg_idx,
  input  logic [W_B-1:0]        cfg_data,
  output logic signed [W_E-1:0] e0_init_t1,
  output logic signed [W_E-1:0] e1_init_t1,
  output logic signed [W_E-1:0] e2_init_t1,
  output logic signed [W_E-1:0] e0_init_t2,
  output logic signed [W_E-1:0] e1_init_t2,
  output logic signed [W_E-1:0] e2_init_t2,
  output logic signed [W_B-1:0] bar_iy,
  output logic signed [W_B-1:0] bar_iz,
  output logic signed [W_B-1:0] bar2_iy,
  output logic signed [W_B-1:0] bar2_iz,
  output logic                  busy,
  output logic                  overrun
);

  localparam int NSLOT = 10;
  localparam logic [3:0] EDGE_SLOTS = 4'd6;
  localparam logic [3:0] K_LAST     = 4'(NSLOT - 1);
  // Trigger column, kept inside the line even if the timing parameters are odd.
  localparam logic [9:0] X_TRIG     = (H_ACTIVE < H_TOTAL) ? 10'(H_ACTIVE) : 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] Y_STEP_END = 10'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_STEP   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] k_q, k_d;

  logic signed [W_B-1:0] start_r [NSLOT];
  logic signed [W_B-1:0] dy_r    [NSLOT];
  logic signed [W_B-1:0] dy_act  [NSLOT];
  logic signed [W_B-1:0] acc     [NSLOT];
  logic signed [W_B-1:0] sum;

  logic       trig_commit;
  logic       trig_step;
  logic       cfg_fire;
  logic       cfg_is_start;
  logic       cfg_is_dy;
  logic [3:0] cfg_slot;

  // Edge slots live in W_E bits: wrap there and keep the upper bits as sign copies.
  function automatic logic signed [W_B-1:0] fit_slot(input logic signed [W_B-1:0] v,
                                                     input logic [3:0] slot);
    logic signed [W_B-1:0] r;
    r = v;
    if (slot < EDGE_SLOTS) r = {{(W_B-W_E){v[W_E-1]}}, v[W_E-1:0]};
    return r;
  endfunction

  assign trig_commit  = (x == X_TRIG) && (y == Y_LAST);
  assign trig_step    = (x == X_TRIG) && (y < Y_STEP_END);
  assign busy         = (state_q != S_IDLE);
  assign cfg_ready    = (state_q != S_COMMIT);
  assign cfg_fire     = cfg_valid && cfg_ready;
  assign cfg_is_start = (cfg_idx < 5'd10);
  assign cfg_is_dy    = (cfg_idx >= 5'd10) && (cfg_idx < 5'd20);
  assign cfg_slot     = cfg_is_start ? cfg_idx[3:0] : 4'(cfg_idx - 5'd10);

  // The one shared adder, always pointed at the slot being stepped this cycle.
  assign sum = acc[k_q] + dy_act[k_q];

  // FSM state, slot counter and sticky overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (busy && (trig_commit || trig_step)) overrun <= 1'b1;
    end
  end

  // Next state: triggers are honoured only from IDLE; sequences run k = 0..9.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        k_d = '0;
        if (trig_commit)    state_d = S_COMMIT;
        else if (trig_step) state_d = S_STEP;
      end
      S_COMMIT, S_STEP: begin
        if (k_q == K_LAST) begin
          state_d = S_IDLE;
          k_d     = '0;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
    endcase
  end

  // Shadow registers take every accepted word; indices above 19 are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        start_r[i] <= '0;
        dy_r[i]    <= '0;
      end
    end else if (cfg_fire && cfg_is_start) begin
      start_r[cfg_slot] <= cfg_data;
    end else if (cfg_fire && cfg_is_dy) begin
      dy_r[cfg_slot] <= cfg_data;
    end
  end

  // Accumulators: COMMIT loads start and freezes this frame's dy, STEP adds it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        acc[i]    <= '0;
        dy_act[i] <= '0;
      end
    end else if (state_q == S_COMMIT) begin
      acc[k_q]    <= fit_slot(start_r[k_q], k_q);
      dy_act[k_q] <= dy_r[k_q];
    end else if (state_q == S_STEP) begin
      acc[k_q] <= fit_slot(sum, k_q);
    end
  end

  assign e0_init_t1 = acc[0][W_E-1:0];
  assign e1_init_t1 = acc[1][W_E-1:0];
  assign e2_init_t1 = acc[2][W_E-1:0];
  assign e0_init_t2 = acc[3][W_E-1:0];
  assign e1_init_t2 = acc[4][W_E-1:0];
  assign e2_init_t2 = acc[5][W_E-1:0];
  assign bar_iy     = acc[6];
  assign bar_iz     = acc[7];
  assign bar2_iy    = acc[8];
  assign bar2_iz    = acc[9];

endmodule

// File: tb/tb_raster_line_sched.sv
// tb_raster_line_sched
// Drives compressed VGA counters (only the hblank window and x==799 of each
// line) and random cfg traffic; a frame-level model predicts every line's
// values as start + n*dy wrapped to the slot width.
module tb_raster_line_sched;

  logic               clk = 1'b0;
  logic               reset;
  logic [9:0]         x, y;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [4:0]         cfg_idx;
  logic [21:0]        cfg_data;
  logic signed [19:0] e0_init_t1, e1_init_t1, e2_init_t1;
  logic signed [19:0] e0_init_t2, e1_init_t2, e2_init_t2;
  logic signed [21:0] bar_iy, bar_iz, bar2_iy, bar2_iz;
  logic               busy, overrun;

  raster_line_sched dut (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .e0_init_t1(e0_init_t1), .e1_init_t1(e1_init_t1), .e2_init_t1(e2_init_t1),
    .e0_init_t2(e0_init_t2), .e1_init_t2(e1_init_t2), .e2_init_t2(e2_init_t2),
    .bar_iy(bar_iy), .bar_iz(bar_iz), .bar2_iy(bar2_iy), .bar2_iz(bar2_iz),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  idx;
    logic [21:0] data;
  } cfg_t;

  cfg_t   cfgq[$];
  int     n_chk = 0;
  int     n_bad = 0;
  int     frame_no = 0;
  longint sh_start[10], sh_dy[10];
  longint fr_start[10], fr_dy[10];
  longint line_n = 0;
  bit     ov_exp = 1'b0;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint wrapw(input longint v, input int w);
    longint u;
    u = v & ((longint'(1) << w) - 1);
    if (u[w-1]) u = u - (longint'(1) << w);
    return u;
  endfunction

  function automatic longint exp_out(input int s);
    return wrapw(fr_start[s] + line_n * fr_dy[s], (s < 6) ? 20 : 22);
  endfunction

  function automatic logic signed [63:0] get_out(input int s);
    logic signed [63:0] r;
    case (s)
      0: r = e0_init_t1;
      1: r = e1_init_t1;
      2: r = e2_init_t1;
      3: r = e0_init_t2;
      4: r = e1_init_t2;
      5: r = e2_init_t2;
      6: r = bar_iy;
      7: r = bar_iz;
      8: r = bar2_iy;
      default: r = bar2_iz;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      sh_start[i] = 0; sh_dy[i] = 0; fr_start[i] = 0; fr_dy[i] = 0;
    end
    line_n = 0;
    ov_exp = 1'b0;
  endtask

  task automatic push(input int idx, input logic [21:0] d);
    cfg_t w;
    w.idx  = 5'(idx);
    w.data = d;
    cfgq.push_back(w);
  endtask

  // One clock: present the queue head, advance, then retire it if it was taken.
  task automatic cycle();
    bit acc_w;
    if (cfgq.size() > 0 && !reset) begin
      cfg_valid = 1'b1;
      cfg_idx   = cfgq[0].idx;
      cfg_data  = cfgq[0].data;
    end else begin
      cfg_valid = 1'b0;
    end
    acc_w = cfg_valid && cfg_ready;
    @(posedge clk); #1;
    if (acc_w) begin
      if (cfgq[0].idx < 10)      sh_start[cfgq[0].idx] = wrapw(longint'(cfgq[0].data), 22);
      else if (cfgq[0].idx < 20) sh_dy[cfgq[0].idx - 10] = wrapw(longint'(cfgq[0].data), 22);
      void'(cfgq.pop_front());
    end
    cfg_valid = 1'b0;
  endtask

  task automatic config_phase();
    y = 10'd524;
    for (int c = 0; c < 200 && cfgq.size() > 0; c++) begin
      x = 10'(c);
      cycle();
    end
    chk("cfg_drain", cfgq.size(), 0);
  endtask

  task automatic push_random_frame();
    for (int s = 0; s < 20; s++) push(s, 22'($urandom));
  endtask

  // mode 0: normal, 1: forced re-trigger at x=645, 2: async reset at x=645
  task automatic run_line(input int yv, input int mode);
    bit trig;
    bit exp_busy;
    trig = (yv == 524) || (yv < 479);
    y = 10'(yv);
    for (int xv = 638; xv <= 656; xv++) begin
      x = (mode == 1 && xv == 645) ? 10'd640 : 10'(xv);
      if (xv == 638 && yv != 524 && $urandom_range(7) == 0)
        push($urandom_range(31), 22'($urandom));
      if (frame_no == 0 && yv == 10 && xv == 643) push(12, 22'd5);
      if (yv == 524 && xv == 640) push(2, 22'd7);
      if (yv == 524 && xv == 641) begin
        push(25, 22'($urandom));
        push($urandom_range(19), 22'($urandom));
        push($urandom_range(19), 22'($urandom));
        push($urandom_range(19), 22'($urandom));
      end
      if (mode == 2 && xv == 645) begin
        #2 reset = 1'b1;
        #1;
        for (int s = 0; s < 10; s++) chk($sformatf("t1_rst_s%0d", s), get_out(s), 0);
        chk("t1_rst_busy", busy, 0);
        chk("t1_rst_ovr", overrun, 0);
        model_reset();
      end
      if (mode == 2 && xv == 646) reset = 1'b0;
      if (xv >= 639 && xv <= 652) begin
        exp_busy = trig && xv >= 641 && xv <= 650 && !(mode == 2 && xv >= 645);
        chk($sformatf("busy_y%0d_x%0d", yv, xv), busy, exp_busy);
      end
      if (yv == 524 && xv >= 639 && xv <= 652)
        chk($sformatf("t5_ready_x%0d", xv), cfg_ready, !(xv >= 641 && xv <= 650));
      if (yv == 524 && xv == 650) chk("t5_pending", cfgq.size(), 4);
      if (mode == 1 && xv == 646) begin
        ov_exp = 1'b1;
        chk("t6_ovr_set", overrun, 1);
      end
      cycle();
      if (xv == 640 && trig) begin
        if (yv == 524) begin
          for (int i = 0; i < 10; i++) begin
            fr_start[i] = sh_start[i];
            fr_dy[i]    = sh_dy[i];
          end
          line_n = 0;
        end else begin
          line_n++;
        end
      end
    end
    x = 10'd799;
    for (int s = 0; s < 10; s++)
      chk($sformatf("f%0d_y%0d_s%0d", frame_no, yv, s), get_out(s), exp_out(s));
    chk($sformatf("ovr_y%0d", yv), overrun, ov_exp);
    cycle();
  endtask

  initial begin
    reset = 1'b1; x = '0; y = '0; cfg_valid = 1'b0; cfg_idx = '0; cfg_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 10; s++) chk($sformatf("rst_s%0d", s), get_out(s), 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_ovr", overrun, 0);
    reset = 1'b0;

    // Frame A: directed slots 0 and 6 over a random background
    frame_no = 0;
    push_random_frame();
    push(0, 22'd100);
    push(10, 22'h3FFFFD);
    push(6, 22'h1FFFFF);
    push(16, 22'd1);
    config_phase();
    run_line(524, 0);
    chk("t2_line0", e0_init_t1, 100);
    chk("t4_e2_start", e2_init_t1, 7);
    for (int yv = 0; yv <= 479; yv++) begin
      run_line(yv, (yv == 20) ? 1 : 0);
      if (yv == 0) begin
        chk("t2_line1", e0_init_t1, 97);
        chk("t3_wrap", bar_iy, -2097152);
      end
      if (yv == 478) chk("t2_line479", e0_init_t1, -1337);
      if (yv == 479) chk("t2_hold479", e0_init_t1, -1337);
    end
    run_line(480, 0);
    run_line(523, 0);

    // Frame B: random config, async reset mid-STEP on line 30
    frame_no = 1;
    push_random_frame();
    config_phase();
    run_line(524, 0);
    chk("t4_e2_start_b", e2_init_t1, 7);
    for (int yv = 0; yv <= 479; yv++) run_line(yv, (yv == 30) ? 2 : 0);

    // Frame C: fresh random config after the reset
    frame_no = 2;
    push_random_frame();
    config_phase();
    run_line(524, 0);
    for (int yv = 0; yv <= 60; yv++) run_line(yv, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
